// File: rtl/timestamp_capture_arbiter.sv
// rtl/timestamp_capture_arbiter.sv - per-requester timestamp capture, round-robin arbiter and show-ahead FIFO
// Optional saturating drop counter built only with TSCAP_DROP_COUNT_EN defined.
module timestamp_capture_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [63:0]                   TimeStamp,
    input  logic [NUM_REQ-1:0]            Trig,
    input  logic                          OvfClear,
    input  logic                          CapReady,
    output logic                          CapValid,
    output logic [63:0]                   CapData,
    output logic [$clog2(NUM_REQ)-1:0]    CapSrc,
    output logic [NUM_REQ-1:0]            Pending,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
    output logic                          Overflow,
    output logic [15:0]                   DropCount
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0]  trig_prev;
    logic [NUM_REQ-1:0]  trig_edge;
    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  grant_vec;
    logic [NUM_REQ-1:0]  drop;
    logic [63:0]         hold [NUM_REQ];
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    grant_idx;
    logic [SRC_W:0]      cand;
    logic                grant_found;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [SRC_W+63:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                overflow;

    assign trig_edge = Trig & ~trig_prev;
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Round-robin search starting at rr_ptr; no grant while the FIFO is full.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_REQ))
                cand = cand - (SRC_W+1)'(NUM_REQ);
            if (!grant_found && !fifo_full && pending[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
        if (grant_found)
            grant_vec[grant_idx] = 1'b1;
    end

    assign drop = trig_edge & pending & ~grant_vec;
    assign push = grant_found;
    assign pop  = CapValid & CapReady;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            trig_prev <= '1;
            pending   <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                hold[i] <= '0;
        end else begin
            trig_prev <= Trig;
            for (int i = 0; i < NUM_REQ; i++) begin
                // A grant frees the holding register in the same cycle a new edge reloads it.
                if (trig_edge[i] && (!pending[i] || grant_vec[i])) begin
                    hold[i]    <= TimeStamp;
                    pending[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (grant_found)
                rr_ptr <= (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {grant_idx, hold[grant_idx]};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            overflow <= 1'b0;
        else if (|drop)
            overflow <= 1'b1;
        else if (OvfClear)
            overflow <= 1'b0;
    end

`ifdef TSCAP_DROP_COUNT_EN
    logic [15:0] drop_cnt;
    logic [16:0] drop_sum;
    logic [15:0] drop_num;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_REQ; i++)
            drop_num = drop_num + 16'(drop[i]);
        drop_sum = {1'b0, drop_cnt} + {1'b0, drop_num};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            drop_cnt <= '0;
        else if (OvfClear)
            drop_cnt <= drop_num;
        else
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign DropCount = drop_cnt;
`else
    assign DropCount = '0;
`endif

    assign Pending   = pending;
    assign FifoCount = fifo_count;
    assign Overflow  = overflow;
    assign CapValid  = (fifo_count != '0);
    assign {CapSrc, CapData} = CapValid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_timestamp_capture_arbiter.sv
// tb/tb_timestamp_capture_arbiter.sv - directed self-checking bench for timestamp_capture_arbiter
module tb_timestamp_capture_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] TimeStamp = '0;
    logic [3:0]  Trig = '0;
    logic        OvfClear = 1'b0;
    logic        CapReady = 1'b0;
    logic        CapValid;
    logic [63:0] CapData;
    logic [1:0]  CapSrc;
    logic [3:0]  Pending;
    logic [4:0]  FifoCount;
    logic        Overflow;
    logic [15:0] DropCount;

    int n_checks = 0;
    int n_fail   = 0;
    logic [65:0] popq [$];

`ifdef TSCAP_DROP_COUNT_EN
    localparam logic [15:0] DROP_EXP = 16'd1;
`else
    localparam logic [15:0] DROP_EXP = 16'd0;
`endif

    timestamp_capture_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .TimeStamp(TimeStamp), .Trig(Trig),
        .OvfClear(OvfClear), .CapReady(CapReady), .CapValid(CapValid),
        .CapData(CapData), .CapSrc(CapSrc), .Pending(Pending),
        .FifoCount(FifoCount), .Overflow(Overflow), .DropCount(DropCount)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock)
        if (!Reset && CapValid && CapReady)
            popq.push_back({CapSrc, CapData});

    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        popq.delete();
    endtask

    task automatic capture(input int r, input logic [63:0] ts);
        Trig = 4'b0001 << r;
        TimeStamp = ts;
        step();
        Trig = '0;
        step();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((FifoCount != 0 || Pending != 0) && n < 200) begin
            step();
            n++;
        end
        check("drain_bound", 80'(n < 200), 80'd1);
    endtask

    initial begin
        // Reset state with Trig[0] held high through release
        Trig = 4'b0001;
        do_reset();
        check("rst_capvalid", 80'(CapValid), 80'd0);
        check("rst_fifocount", 80'(FifoCount), 80'd0);
        check("rst_capdata", 80'(CapData), 80'd0);
        check("rst_overflow", 80'(Overflow), 80'd0);
        check("rst_dropcount", 80'(DropCount), 80'd0);
        step();
        step();
        check("held_trig_pending", 80'(Pending), 80'd0);
        check("held_trig_fifo", 80'(FifoCount), 80'd0);
        Trig = '0;

        // Single capture on requester 2
        do_reset();
        CapReady = 1'b1;
        TimeStamp = 64'h0000_0010_0000_0005;
        Trig = 4'b0100;
        step();
        check("single_pending", 80'(Pending), 80'h4);
        check("single_notyet", 80'(CapValid), 80'd0);
        TimeStamp = 64'hDEAD;
        step();
        check("single_valid", 80'(CapValid), 80'd1);
        check("single_src", 80'(CapSrc), 80'd2);
        check("single_data", 80'(CapData), 80'h0000_0010_0000_0005);
        step();
        check("single_popped", 80'(CapValid), 80'd0);
        check("single_npop", 80'(popq.size()), 80'd1);
        Trig = '0;

        // Round robin, then wrap from requester 3
        do_reset();
        CapReady = 1'b1;
        TimeStamp = 64'hA;
        Trig = 4'b1111;
        step();
        Trig = '0;
        wait_drain();
        TimeStamp = 64'hB;
        Trig = 4'b0011;
        step();
        Trig = '0;
        wait_drain();
        step();
        check("rr_npop", 80'(popq.size()), 80'd6);
        if (popq.size() == 6) begin
            check("rr_pop0", 80'(popq[0]), {14'd0, 2'd0, 64'hA});
            check("rr_pop1", 80'(popq[1]), {14'd0, 2'd1, 64'hA});
            check("rr_pop2", 80'(popq[2]), {14'd0, 2'd2, 64'hA});
            check("rr_pop3", 80'(popq[3]), {14'd0, 2'd3, 64'hA});
            check("rr_pop4", 80'(popq[4]), {14'd0, 2'd0, 64'hB});
            check("rr_pop5", 80'(popq[5]), {14'd0, 2'd1, 64'hB});
        end

        // Full FIFO: 17 captures with consumer stalled
        do_reset();
        CapReady = 1'b0;
        for (int i = 0; i < 17; i++)
            capture(i % 4, 64'h100 + 64'(i));
        step();
        check("full_count", 80'(FifoCount), 80'd16);
        check("full_pending", 80'(Pending), 80'h1);
        check("full_head", 80'({CapSrc, CapData}), {14'd0, 2'd0, 64'h100});
        check("full_no_ovf", 80'(Overflow), 80'd0);
        CapReady = 1'b1;
        wait_drain();
        step();
        check("full_npop", 80'(popq.size()), 80'd17);
        if (popq.size() == 17)
            for (int i = 0; i < 17; i++)
                check($sformatf("full_pop%0d", i), 80'(popq[i]),
                      {14'd0, 2'(i % 4), 64'h100 + 64'(i)});
        check("full_ovf_after", 80'(Overflow), 80'd0);

        // Drop while full, clear, then clear and drop in the same cycle
        do_reset();
        CapReady = 1'b0;
        for (int i = 0; i < 16; i++)
            capture(i % 4, 64'h200 + 64'(i));
        check("drop_full", 80'(FifoCount), 80'd16);
        capture(1, 64'h300);
        check("drop_first_held", 80'(Overflow), 80'd0);
        capture(1, 64'h301);
        check("drop_ovf", 80'(Overflow), 80'd1);
        check("drop_cnt", 80'(DropCount), 80'(DROP_EXP));
        check("drop_pending", 80'(Pending), 80'h2);
        OvfClear = 1'b1;
        step();
        OvfClear = 1'b0;
        check("clr_ovf", 80'(Overflow), 80'd0);
        check("clr_cnt", 80'(DropCount), 80'd0);
        Trig = 4'b0010;
        OvfClear = 1'b1;
        step();
        OvfClear = 1'b0;
        Trig = '0;
        check("setwins_ovf", 80'(Overflow), 80'd1);
        check("setwins_cnt", 80'(DropCount), 80'(DROP_EXP));
        CapReady = 1'b1;
        wait_drain();
        check("drop_drain_n", 80'(popq.size()), 80'd17);
        if (popq.size() == 17)
            check("drop_kept_old", 80'(popq[16]), {14'd0, 2'd1, 64'h300});

        // Asynchronous reset with entries queued
        do_reset();
        CapReady = 1'b0;
        for (int i = 0; i < 3; i++)
            capture(i, 64'h400 + 64'(i));
        check("mid_count", 80'(FifoCount), 80'd3);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_valid", 80'(CapValid), 80'd0);
        check("mid_rst_count", 80'(FifoCount), 80'd0);
        check("mid_rst_pending", 80'(Pending), 80'd0);
        check("mid_rst_data", 80'(CapData), 80'd0);
        step();
        Reset = 1'b0;
        step();
        check("mid_after_valid", 80'(CapValid), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
